rgb_stream_packer: RTL and testbench

- Converts a stream of 24-bit RGB pixels (one per handshake) into a byte-packed 32-bit AXI4-Stream video output: every 4 pixels become 3 words.
- Sits between the fractal pixel generator and the VDMA/video stream output.
- Carries start-of-frame onto TUSER[0] and end-of-line onto TLAST.
- Absorbs downstream backpressure by throttling the pixel source.

---
 rtl/rgb_stream_packer_if.sv | 51 +++++
 rtl/rgb_stream_packer.sv | 161 ++++++++++++++++
 tb/tb_rgb_stream_packer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rgb_stream_packer_if.sv
// rgb_stream_packer_if
//   Bundles the pixel input stream, the packed 32-bit AXI4-Stream output and
//   the packer's internal state for observation.
//   Handshake rule for both streams: a beat moves on a rising clock edge
//   where the sender's valid and the receiver's ready are both high. A sender
//   holds its payload stable while valid is high and ready is low.
//
//   Signals:
//     r, g, b            pixel colour bytes
//     valid              pixel on r/g/b/sof/eol is valid
//     sof, eol           pixel is first of frame / last of line
//     in_stream_ready    packer accepts a pixel this cycle
//     out_stream_t*      packed output word (tdata/tkeep/tlast/tuser/tvalid)
//     out_stream_tready  downstream accepts the word
//     dbg_phase          byte-packing phase (0..3)
//     dbg_flush_pending  end-of-line remainder word waiting for the output
//     dbg_sof_pending    next emitted word carries tuser
//
//   Modports: slave = the packer, master = the pixel source plus sink.
interface rgb_stream_packer_if;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        valid;
    logic        sof;
    logic        eol;
    logic        in_stream_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;
    logic [1:0]  dbg_phase;
    logic        dbg_flush_pending;
    logic        dbg_sof_pending;

    modport slave (
        input  r, g, b, valid, sof, eol, out_stream_tready,
        output in_stream_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid,
               dbg_phase, dbg_flush_pending, dbg_sof_pending
    );

    modport master (
        output r, g, b, valid, sof, eol, out_stream_tready,
        input  in_stream_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid,
               dbg_phase, dbg_flush_pending, dbg_sof_pending
    );
endinterface

// File: rtl/rgb_stream_packer.sv
// rgb_stream_packer
//   Packs 24-bit pixels P = {r, b, g} little-endian into 32-bit words, so
//   every 4 pixels become 3 words. sof is carried on tuser of the first word
//   of the frame, eol on tlast of the last word of the line. A line that ends
//   mid-word is closed with a partial word (tkeep 7, 3 or 1).
//
//   Ports:
//     aclk     clock, rising edge
//     aresetn  asynchronous active-low reset
//     bus      rgb_stream_packer_if.slave (pixel in, packed words out, state)
module rgb_stream_packer (
    input  logic                 aclk,
    input  logic                 aresetn,
    rgb_stream_packer_if.slave   bus
);
    // Phase = number of pixels already folded into the current 3-word group.
    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    phase_t      phase;
    logic [23:0] residual;
    logic        sof_pending;
    logic        flush_pending;

    logic [31:0] tdata_q;
    logic [3:0]  tkeep_q;
    logic        tlast_q;
    logic        tuser_q;
    logic        tvalid_q;

    logic [23:0] pix;
    logic        out_free;
    logic        ready;
    logic        accept;
    phase_t      eff_phase;
    logic        sof_now;

    logic        emit;
    logic [31:0] emit_data;
    logic [3:0]  emit_keep;
    logic        emit_last;
    phase_t      nxt_phase;
    logic [23:0] nxt_residual;
    logic        nxt_flush;

    always_comb begin
        pix       = {bus.r, bus.b, bus.g};
        out_free  = !tvalid_q || bus.out_stream_tready;
        ready     = !flush_pending && out_free;
        accept    = bus.valid && ready;
        // A sof pixel restarts packing: leftover bytes of the old line are dropped.
        eff_phase = bus.sof ? PH0 : phase;
        sof_now   = sof_pending || (accept && bus.sof);

        emit         = 1'b0;
        emit_data    = 32'h0;
        emit_keep    = 4'hF;
        emit_last    = 1'b0;
        nxt_phase    = phase;
        nxt_residual = residual;
        nxt_flush    = flush_pending;

        if (flush_pending) begin
            // Remainder word; the phase left behind says how many bytes remain.
            if (out_free) begin
                emit         = 1'b1;
                emit_last    = 1'b1;
                if (phase == PH2) begin
                    emit_data = {16'h0, residual[15:0]};
                    emit_keep = 4'h3;
                end else begin
                    emit_data = {24'h0, residual[7:0]};
                    emit_keep = 4'h1;
                end
                nxt_residual = 24'h0;
                nxt_phase    = PH0;
                nxt_flush    = 1'b0;
            end
        end else if (accept) begin
            case (eff_phase)
                PH0: begin
                    if (bus.eol) begin
                        emit         = 1'b1;
                        emit_data    = {8'h00, pix};
                        emit_keep    = 4'h7;
                        emit_last    = 1'b1;
                        nxt_residual = 24'h0;
                        nxt_phase    = PH0;
                    end else begin
                        nxt_residual = pix;
                        nxt_phase    = PH1;
                    end
                end
                PH1: begin
                    emit         = 1'b1;
                    emit_data    = {pix[7:0], residual[23:0]};
                    nxt_residual = {8'h00, pix[23:8]};
                    nxt_phase    = PH2;
                    nxt_flush    = bus.eol;
                end
                PH2: begin
                    emit         = 1'b1;
                    emit_data    = {pix[15:0], residual[15:0]};
                    nxt_residual = {16'h0, pix[23:16]};
                    nxt_phase    = PH3;
                    nxt_flush    = bus.eol;
                end
                PH3: begin
                    emit         = 1'b1;
                    emit_data    = {pix, residual[7:0]};
                    emit_last    = bus.eol;
                    nxt_residual = 24'h0;
                    nxt_phase    = PH0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase         <= PH0;
            residual      <= 24'h0;
            sof_pending   <= 1'b0;
            flush_pending <= 1'b0;
            tdata_q       <= 32'h0;
            tkeep_q       <= 4'h0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            tvalid_q      <= 1'b0;
        end else begin
            phase         <= nxt_phase;
            residual      <= nxt_residual;
            flush_pending <= nxt_flush;
            if (emit) begin
                tvalid_q    <= 1'b1;
                tdata_q     <= emit_data;
                tkeep_q     <= emit_keep;
                tlast_q     <= emit_last;
                tuser_q     <= sof_now;
                sof_pending <= 1'b0;
            end else begin
                if (bus.out_stream_tready) begin
                    tvalid_q <= 1'b0;
                end
                if (accept && bus.sof) begin
                    sof_pending <= 1'b1;
                end
            end
        end
    end

    assign bus.in_stream_ready   = ready;
    assign bus.out_stream_tdata  = tdata_q;
    assign bus.out_stream_tkeep  = tkeep_q;
    assign bus.out_stream_tlast  = tlast_q;
    assign bus.out_stream_tuser  = tuser_q;
    assign bus.out_stream_tvalid = tvalid_q;
    assign bus.dbg_phase         = phase;
    assign bus.dbg_flush_pending = flush_pending;
    assign bus.dbg_sof_pending   = sof_pending;
endmodule

// File: tb/tb_rgb_stream_packer.sv
// tb_rgb_stream_packer
//   Directed bench for rgb_stream_packer: four-pixel line, backpressure,
//   eol at phases 1 and 0, mid-line async reset, and two 640-pixel lines.
module tb_rgb_stream_packer;
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    rgb_stream_packer_if bus ();

    rgb_stream_packer dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    // Clock / reset
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Beat format: {tuser, tlast, tkeep[3:0], tdata[31:0]}
    logic [37:0] exp_q[$];
    logic [37:0] got_q[$];

    always @(negedge aclk) begin
        if (aresetn && bus.out_stream_tvalid && bus.out_stream_tready)
            got_q.push_back({bus.out_stream_tuser, bus.out_stream_tlast,
                             bus.out_stream_tkeep, bus.out_stream_tdata});
    end

    function automatic logic [37:0] beat(input logic user, input logic last,
                                         input logic [3:0] keep, input logic [31:0] data);
        return {user, last, keep, data};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Driver: present one pixel and hold it until the packer accepts it.
    // Returns #1 after the accepting edge with valid dropped.
    task automatic send_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic s, input logic e);
        bit done;
        done      = 1'b0;
        bus.r     = r;
        bus.g     = g;
        bus.b     = b;
        bus.sof   = s;
        bus.eol   = e;
        bus.valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge aclk);
            if (bus.in_stream_ready) done = 1'b1;
            @(posedge aclk);
            #1;
        end
        bus.valid = 1'b0;
        bus.sof   = 1'b0;
        bus.eol   = 1'b0;
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    // Scoreboard: wait for the expected number of beats, then compare in order.
    task automatic drain_check(input string tag, input int budget);
        for (int i = 0; i < budget && got_q.size() < exp_q.size(); i++)
            @(posedge aclk);
        repeat (4) @(posedge aclk);
        #1;
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic send_line4();
        send_px(8'h11, 8'h12, 8'h13, 1'b1, 1'b0);
        send_px(8'h21, 8'h22, 8'h23, 1'b0, 1'b0);
        send_px(8'h31, 8'h32, 8'h33, 1'b0, 1'b0);
        send_px(8'h41, 8'h42, 8'h43, 1'b0, 1'b1);
    endtask

    task automatic push_line4_exp();
        exp_q.push_back(beat(1'b1, 1'b0, 4'hF, 32'h22111312));
        exp_q.push_back(beat(1'b0, 1'b0, 4'hF, 32'h33322123));
        exp_q.push_back(beat(1'b0, 1'b1, 4'hF, 32'h41434231));
    endtask

    logic [7:0]  bq[$];
    logic [7:0]  pr, pg, pb;
    logic        first_word;
    logic [31:0] w;

    initial begin
        bus.r = 8'h0; bus.g = 8'h0; bus.b = 8'h0;
        bus.valid = 1'b0; bus.sof = 1'b0; bus.eol = 1'b0;
        bus.out_stream_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 64'(bus.out_stream_tvalid), 64'd0);
        check("rst_tdata",  64'(bus.out_stream_tdata),  64'd0);
        check("rst_tkeep",  64'(bus.out_stream_tkeep),  64'd0);
        check("rst_tlast",  64'(bus.out_stream_tlast),  64'd0);
        check("rst_tuser",  64'(bus.out_stream_tuser),  64'd0);
        check("rst_ready",  64'(bus.in_stream_ready),   64'd1);
        check("rst_phase",  64'(bus.dbg_phase),         64'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Four-pixel line, tready held high
        send_px(8'h11, 8'h12, 8'h13, 1'b1, 1'b0);
        check("s1_no_word_after_p0", 64'(bus.out_stream_tvalid), 64'd0);
        send_px(8'h21, 8'h22, 8'h23, 1'b0, 1'b0);
        check("s1_tvalid_after_p1", 64'(bus.out_stream_tvalid), 64'd1);
        check("s1_tdata_after_p1",  64'(bus.out_stream_tdata),  64'h22111312);
        check("s1_tuser_after_p1",  64'(bus.out_stream_tuser),  64'd1);
        send_px(8'h31, 8'h32, 8'h33, 1'b0, 1'b0);
        send_px(8'h41, 8'h42, 8'h43, 1'b0, 1'b1);
        push_line4_exp();
        drain_check("s1", 100);

        // Backpressure: first word stalled for 5 cycles
        bus.out_stream_tready = 1'b0;
        send_px(8'h11, 8'h12, 8'h13, 1'b1, 1'b0);
        send_px(8'h21, 8'h22, 8'h23, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check($sformatf("s2_stall_tvalid%0d", i), 64'(bus.out_stream_tvalid), 64'd1);
            check($sformatf("s2_stall_tdata%0d", i),  64'(bus.out_stream_tdata),  64'h22111312);
            check($sformatf("s2_stall_ready%0d", i),  64'(bus.in_stream_ready),   64'd0);
        end
        @(posedge aclk);
        #1;
        bus.out_stream_tready = 1'b1;
        send_px(8'h31, 8'h32, 8'h33, 1'b0, 1'b0);
        send_px(8'h41, 8'h42, 8'h43, 1'b0, 1'b1);
        push_line4_exp();
        drain_check("s2", 100);

        // eol at phase 1: flush word with 2 bytes
        send_px(8'h11, 8'h12, 8'h13, 1'b1, 1'b0);
        send_px(8'h21, 8'h22, 8'h23, 1'b0, 1'b1);
        check("s3_flush_pending", 64'(bus.dbg_flush_pending), 64'd1);
        check("s3_flush_ready",   64'(bus.in_stream_ready),   64'd0);
        exp_q.push_back(beat(1'b1, 1'b0, 4'hF, 32'h22111312));
        exp_q.push_back(beat(1'b0, 1'b1, 4'h3, 32'h00002123));
        drain_check("s3", 100);
        check("s3_ready_after", 64'(bus.in_stream_ready), 64'd1);

        // eol at phase 2: flush word with 1 byte
        send_px(8'h11, 8'h12, 8'h13, 1'b1, 1'b0);
        send_px(8'h21, 8'h22, 8'h23, 1'b0, 1'b0);
        send_px(8'h31, 8'h32, 8'h33, 1'b0, 1'b1);
        exp_q.push_back(beat(1'b1, 1'b0, 4'hF, 32'h22111312));
        exp_q.push_back(beat(1'b0, 1'b0, 4'hF, 32'h33322123));
        exp_q.push_back(beat(1'b0, 1'b1, 4'h1, 32'h00000031));
        drain_check("s3b", 100);

        // eol at phase 0, same pixel as sof
        send_px(8'h11, 8'h12, 8'h13, 1'b1, 1'b1);
        exp_q.push_back(beat(1'b1, 1'b1, 4'h7, 32'h00111312));
        drain_check("s4", 100);

        // Async reset in the middle of a line
        send_px(8'h11, 8'h12, 8'h13, 1'b1, 1'b0);
        send_px(8'h21, 8'h22, 8'h23, 1'b0, 1'b0);
        check("s5_tvalid_before_rst", 64'(bus.out_stream_tvalid), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("s5_tvalid_in_rst", 64'(bus.out_stream_tvalid), 64'd0);
        check("s5_phase_in_rst",  64'(bus.dbg_phase),         64'd0);
        check("s5_ready_in_rst",  64'(bus.in_stream_ready),   64'd1);
        #2;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        send_line4();
        push_line4_exp();
        drain_check("s5", 100);

        // Two 640-pixel lines against a byte-queue model
        first_word = 1'b1;
        for (int line = 0; line < 2; line++) begin
            for (int i = 0; i < 640; i++) begin
                pr = 8'(i);
                pg = 8'(i * 3) ^ 8'(line * 8'h5A);
                pb = 8'(i >> 2) + 8'(line);
                send_px(pr, pg, pb, (line == 0 && i == 0), (i == 639));
                bq.push_back(pg);
                bq.push_back(pb);
                bq.push_back(pr);
                while (bq.size() >= 4) begin
                    w = {bq[3], bq[2], bq[1], bq[0]};
                    repeat (4) void'(bq.pop_front());
                    exp_q.push_back(beat(first_word, (i == 639) && (bq.size() == 0), 4'hF, w));
                    first_word = 1'b0;
                end
            end
            // 640 pixels fill whole words, so nothing is left to pad
            check($sformatf("s6_model_leftover%0d", line), 64'(bq.size()), 64'd0);
        end
        drain_check("s6", 3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
